// File: rtl/alu_pkg.sv
// Shared opcode constants and helpers for the yAlu issue stage.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b110;
    localparam logic [2:0] ALU_OP_SLT = 3'b111;

    // True for the five opcodes the yAlu implements.
    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            ALU_OP_AND, ALU_OP_OR, ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Show-ahead synchronous FIFO holding packed ALU requests.
// Writes while full and reads while empty are dropped internally.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DATA_W = 2 * ALU_WIDTH + 3,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic              do_wr, do_rd;

    assign full    = (count_q == OCC_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Next pointers wrap naturally at DEPTH; occupancy nets out push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage for the yAlu: queues requests, drives the head entry to the
// ALU and captures its result into a valid/ready output slot.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_ex,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_ex,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [CNT_W-1:0] done_count
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
    } req_t;

    req_t             wr_req, head;
    logic             fifo_full, fifo_empty;
    logic             push, pop, head_illegal;
    logic [WIDTH-1:0] cap_z;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_z_q, out_z_d;
    logic             out_ex_q, out_ex_d;
    logic             out_zero_q, out_zero_d;
    logic             out_illegal_q, out_illegal_d;
    logic [CNT_W-1:0] done_count_q, done_count_d;

    assign wr_req   = '{a: in_a, b: in_b, op: in_op};
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    // The slot frees up in the same cycle it is consumed, giving full throughput.
    assign pop      = !fifo_empty && (!out_valid_q || out_ready);

    alu_req_fifo #(
        .DATA_W ($bits(req_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (wr_req),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Present the head request to the ALU, forced to zero when nothing is queued.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_OP_AND;
        if (!fifo_empty) begin
            alu_a  = head.a;
            alu_b  = head.b;
            alu_op = head.op;
        end
    end

    assign head_illegal = !is_legal_op(alu_op);
    assign cap_z        = head_illegal ? '0 : alu_z;

    // Output slot: capture on pop, drop valid when drained, count consumptions.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_z_d       = out_z_q;
        out_ex_d      = out_ex_q;
        out_zero_d    = out_zero_q;
        out_illegal_d = out_illegal_q;
        done_count_d  = done_count_q;
        if (pop) begin
            out_valid_d   = 1'b1;
            out_z_d       = cap_z;
            out_ex_d      = head_illegal ? 1'b0 : alu_ex;
            out_zero_d    = (cap_z == '0);
            out_illegal_d = head_illegal;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (out_valid_q && out_ready) done_count_d = done_count_q + CNT_W'(1);
    end

    // Output slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_z_q       <= '0;
            out_ex_q      <= 1'b0;
            out_zero_q    <= 1'b0;
            out_illegal_q <= 1'b0;
            done_count_q  <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_z_q       <= out_z_d;
            out_ex_q      <= out_ex_d;
            out_zero_q    <= out_zero_d;
            out_illegal_q <= out_illegal_d;
            done_count_q  <= done_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_z       = out_z_q;
    assign out_ex      = out_ex_q;
    assign out_zero    = out_zero_q;
    assign out_illegal = out_illegal_q;
    assign done_count  = done_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: attaches a behavioural yAlu, runs a vector
// table, directed backpressure/reset sequences and a randomized stream
// checked against an in-order scoreboard.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic [2:0]  in_op;
    logic [31:0] alu_a, alu_b, alu_z;
    logic [2:0]  alu_op;
    logic        alu_ex;
    logic        out_valid, out_ready;
    logic [31:0] out_z;
    logic        out_ex, out_zero, out_illegal;
    logic [15:0] done_count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] z;
        logic        ex;
        logic        zero;
        logic        ill;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        res_t        exp;
    } vec_t;

    res_t exp_q[$];
    vec_t vt[11];

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_z       (alu_z),
        .alu_ex      (alu_ex),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_z       (out_z),
        .out_ex      (out_ex),
        .out_zero    (out_zero),
        .out_illegal (out_illegal),
        .done_count  (done_count)
    );

    // Behavioural yAlu; unknown opcodes return garbage so gating is observable.
    always_comb begin
        alu_z  = 32'hDEAD_BEEF;
        alu_ex = 1'b1;
        case (alu_op)
            3'b000: begin alu_z = alu_a & alu_b; alu_ex = 1'b0; end
            3'b001: begin alu_z = alu_a | alu_b; alu_ex = 1'b0; end
            3'b010: begin
                alu_z  = alu_a + alu_b;
                alu_ex = (alu_a[31] == alu_b[31]) && (alu_z[31] != alu_a[31]);
            end
            3'b110: begin
                alu_z  = alu_a - alu_b;
                alu_ex = (alu_a[31] != alu_b[31]) && (alu_z[31] != alu_a[31]);
            end
            3'b111: begin alu_z = {31'd0, $signed(alu_a) < $signed(alu_b)}; alu_ex = 1'b0; end
            default: ;
        endcase
    end

    // Reference result computed with wide signed arithmetic.
    function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] op);
        res_t   r;
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint s  = 0;
        r = '0;
        case (op)
            3'b000: r.z = a & b;
            3'b001: r.z = a | b;
            3'b010: begin s = sa + sb; r.z = s[31:0]; r.ex = (s != longint'($signed(r.z))); end
            3'b110: begin s = sa - sb; r.z = s[31:0]; r.ex = (s != longint'($signed(r.z))); end
            3'b111: r.z = (sa < sb) ? 32'd1 : 32'd0;
            default: r.ill = 1'b1;
        endcase
        r.zero = (r.z == 32'd0);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle starting and ending at a negedge; scoreboards both handshakes.
    task automatic cyc(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic ordy);
        res_t e;
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = ordy;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("sb_result", {29'd0, out_z, out_ex, out_zero, out_illegal}, {29'd0, e});
            end
        end
        if (in_valid && in_ready) exp_q.push_back(ref_model(a, b, op));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int sent;
        int budget;
        logic iv;

        vt[0]  = '{32'd5,        32'd7,        3'b010, '{32'd12,        1'b0, 1'b0, 1'b0}};
        vt[1]  = '{32'd9,        32'd9,        3'b110, '{32'd0,         1'b0, 1'b1, 1'b0}};
        vt[2]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, '{32'h00F000F0,  1'b0, 1'b0, 1'b0}};
        vt[3]  = '{32'd1,        32'd2,        3'b011, '{32'd0,         1'b0, 1'b1, 1'b1}};
        vt[4]  = '{32'd1,        32'd2,        3'b001, '{32'd3,         1'b0, 1'b0, 1'b0}};
        vt[5]  = '{32'hFFFFFFFF, 32'd1,        3'b111, '{32'd1,         1'b0, 1'b0, 1'b0}};
        vt[6]  = '{32'd1,        32'hFFFFFFFF, 3'b111, '{32'd0,         1'b0, 1'b1, 1'b0}};
        vt[7]  = '{32'h7FFFFFFF, 32'd1,        3'b010, '{32'h80000000,  1'b1, 1'b0, 1'b0}};
        vt[8]  = '{32'd0,        32'd1,        3'b110, '{32'hFFFFFFFF,  1'b0, 1'b0, 1'b0}};
        vt[9]  = '{32'h80000000, 32'd1,        3'b110, '{32'h7FFFFFFF,  1'b1, 1'b0, 1'b0}};
        vt[10] = '{32'h12345678, 32'h1,        3'b101, '{32'd0,         1'b0, 1'b1, 1'b1}};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready",   {63'd0, in_ready},  64'd1);
        chk("rst_out_valid",  {63'd0, out_valid}, 64'd0);
        chk("rst_out_fields", {29'd0, out_z, out_ex, out_zero, out_illegal}, 64'd0);
        chk("rst_done_count", {48'd0, done_count}, 64'd0);
        chk("rst_alu_bus",    {29'd0, alu_a[15:0], alu_b[15:0], alu_op}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table: accept, check latency and captured fields, consume.
        for (int i = 0; i < 11; i++) begin
            cyc(1'b1, vt[i].a, vt[i].b, vt[i].op, 1'b0);
            chk("vec_lat_not_yet", {63'd0, out_valid}, 64'd0);
            cyc(1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b010, 1'b0);
            chk("vec_valid", {63'd0, out_valid}, 64'd1);
            chk("vec_result", {29'd0, out_z, out_ex, out_zero, out_illegal}, {29'd0, vt[i].exp});
            cyc(1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
            chk("vec_drained", {63'd0, out_valid}, 64'd0);
            chk("vec_done_count", {48'd0, done_count}, 64'(i + 1));
            chk("vec_idle_alu", {alu_a, 29'd0, alu_op}, 64'd0);
        end
        out_ready = 1'b0;

        // Backpressure: five ADDs with the consumer stalled.
        for (int k = 0; k < 5; k++) cyc(1'b1, 32'(k * 16 + 1), 32'(k + 3), 3'b010, 1'b0);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("bp_slot_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_slot_first", {32'd0, out_z}, 64'd4);
        cyc(1'b1, 32'd99, 32'd99, 3'b010, 1'b0);
        chk("bp_slot_held", {32'd0, out_z}, 64'd4);
        for (int k = 0; k < 5; k++) begin
            chk("bp_stream_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_stream_order", {32'd0, out_z}, 64'(k * 17 + 4));
            cyc(1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
        end
        chk("bp_drained", {63'd0, out_valid}, 64'd0);
        chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("bp_done_count", {48'd0, done_count}, 64'd16);

        // Reset mid-operation: one result held and three queued.
        for (int k = 0; k < 4; k++) cyc(1'b1, 32'(k + 10), 32'd20, 3'b010, 1'b0);
        chk("mid_pre_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  {63'd0, out_valid}, 64'd0);
        chk("mid_rst_fields", {29'd0, out_z, out_ex, out_zero, out_illegal}, 64'd0);
        chk("mid_rst_count",  {48'd0, done_count}, 64'd0);
        chk("mid_rst_ready",  {63'd0, in_ready}, 64'd1);
        chk("mid_rst_alu",    {alu_a, 29'd0, alu_op}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
            chk("mid_no_stale", {63'd0, out_valid}, 64'd0);
        end

        // Randomized stream with random backpressure.
        sent = 0;
        budget = 0;
        while ((sent < 20 || exp_q.size() != 0 || out_valid) && budget < 3000) begin
            iv = (sent < 20) && ($urandom_range(0, 1) == 1);
            if (iv && in_ready) sent++;
            cyc(iv, $urandom(), ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom(),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            budget++;
        end
        if (budget >= 3000) chk("stream_timeout", 64'd0, 64'd1);
        chk("stream_done_count", {48'd0, done_count}, 64'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
